// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame size, sample layout and index bit reversal.
// The reversal function is width-generic up to BITREV_MAX_W bits.
package fft_pkg;

   localparam int N_LOG2_DEF   = 4;
   localparam int BITREV_MAX_W = 16;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
   } sample_t;

   // Reverses the low n_log2 bits of k; bits above n_log2 come back as zero.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] k,
                                                      input int n_log2);
      logic [BITREV_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < BITREV_MAX_W; i++) begin
         if (i < n_log2) r[i] = k[n_log2-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/bitrev_index.sv
// Combinational N_LOG2-bit index reversal for the reorder buffer write address.
// Zero latency; no flow control.
module bitrev_index
   import fft_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEF
) (
   input  logic [N_LOG2-1:0] i_idx,
   output logic [N_LOG2-1:0] o_idx
);

   assign o_idx = N_LOG2'(bitrev(BITREV_MAX_W'(i_idx), N_LOG2));

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes FFT-order samples to bitrev(k), reads natural order.
// First output one edge after a frame completes; in_ready drops only while both banks are full.
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEF,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [N_LOG2-1:0] out_index,
   output logic              out_last,
   output logic              frame_err
);

   localparam int N = 1 << N_LOG2;
   localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

   logic [DATA_W-1:0] r_mem [2*N];

   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [N_LOG2-1:0] r_wr_cnt;
   logic [N_LOG2-1:0] r_rd_cnt;
   logic [1:0]        r_full;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [N_LOG2-1:0] r_out_index;
   logic              r_out_last;
   logic              r_frame_err;

   logic [N_LOG2-1:0] w_wr_addr;
   logic              w_wr_acc;
   logic              w_wr_wrap;
   logic              w_load;
   logic              w_rd_wrap;
   logic [1:0]        w_full_nxt;

   bitrev_index #(
      .N_LOG2 (N_LOG2)
   ) u_bitrev (
      .i_idx (r_wr_cnt),
      .o_idx (w_wr_addr)
   );

   assign in_ready  = !r_full[r_wr_bank];
   assign w_wr_acc  = in_valid && in_ready;
   assign w_wr_wrap = (r_wr_cnt == LAST_IDX);
   assign w_load    = r_full[r_rd_bank] && (!r_out_valid || out_ready);
   assign w_rd_wrap = (r_rd_cnt == LAST_IDX);

   // Writer and reader never own the same bank, so set and clear never collide.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_acc && w_wr_wrap) w_full_nxt[r_wr_bank] = 1'b1;
      if (w_load && w_rd_wrap)   w_full_nxt[r_rd_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[{r_wr_bank, w_wr_addr}] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_full      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_wr_acc) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_wrap) r_wr_bank <= !r_wr_bank;
            // in_last only flags framing errors; the count alone defines the frame.
            if (in_last != w_wr_wrap) r_frame_err <= 1'b1;
         end
         if (w_load) begin
            r_out_data  <= r_mem[{r_rd_bank, r_rd_cnt}];
            r_out_index <= r_rd_cnt;
            r_out_last  <= w_rd_wrap;
            r_out_valid <= 1'b1;
            r_rd_cnt    <= r_rd_cnt + 1'b1;
            if (w_rd_wrap) r_rd_bank <= !r_rd_bank;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_index = r_out_index;
   assign out_last  = r_out_last;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with N_LOG2 = 4 and in_data = k.
module tb_fft_bitrev_reorder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_index;
   logic        out_last;
   logic        frame_err;

   int checks;
   int errors;
   int cyc;
   int stalls;
   int stall_err;
   int stall_cyc;

   logic [31:0] q_data [$];
   logic [3:0]  q_idx  [$];
   logic        q_last [$];
   int          q_cyc  [$];

   logic        held_vld;
   logic [31:0] h_data;
   logic [3:0]  h_idx;
   logic        h_last;

   logic [31:0] exp_ord [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   fft_bitrev_reorder #(
      .N_LOG2 (4),
      .DATA_W (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Output log and hold-while-stalled watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (held_vld) begin
         if (!(out_valid === 1'b1 && out_data === h_data && out_index === h_idx && out_last === h_last))
            stall_err++;
      end
      if (rst_n && out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_idx.push_back(out_index);
         q_last.push_back(out_last);
         q_cyc.push_back(cyc);
      end
      held_vld = rst_n && out_valid && !out_ready;
      if (held_vld) begin
         stall_cyc++;
         h_data = out_data;
         h_idx  = out_index;
         h_last = out_last;
      end
   end

   task automatic clear_log();
      q_data.delete();
      q_idx.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one sample and returns #1 after the edge that accepted it.
   task automatic send_one(input logic [31:0] d, input logic last);
      int w;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      w = 0;
      while (!in_ready && w < 200) begin
         tick();
         w++;
      end
      stalls += w;
      if (w >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout data=%0d: in_ready stayed 0 for %0d cycles, required 1", d, w);
      end else begin
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_log(input int n, output int got);
      int w;
      w = 0;
      while (q_data.size() < n && w < 400) begin
         tick();
         w++;
      end
      got = q_data.size();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
      checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_out_index got %0d want 0", out_index); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      int got;
      clear_log();
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) send_one(32'(k), k == 15);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early out_valid=%b at last accept edge, want 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_data !== 32'd0)
         begin errors++; $display("FAIL single_first_word valid=%b idx=%0d data=%0d want 1/0/0", out_valid, out_index, out_data); end
      wait_log(16, got);
      checks++; if (got != 16) begin errors++; $display("FAIL single_count got %0d words want 16", got); end
      for (int j = 0; j < q_data.size(); j++) begin
         checks++; if (q_data[j] !== exp_ord[j]) begin errors++; $display("FAIL single_data[%0d] got %0d want %0d", j, q_data[j], exp_ord[j]); end
         checks++; if (q_idx[j] !== 4'(j)) begin errors++; $display("FAIL single_index[%0d] got %0d want %0d", j, q_idx[j], j); end
         checks++; if (q_last[j] !== (j == 15)) begin errors++; $display("FAIL single_last[%0d] got %b want %b", j, q_last[j], j == 15); end
      end
   endtask

   task automatic test_back_to_back();
      int got;
      logic [31:0] e;
      clear_log();
      stalls = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 32; k++) send_one(32'(k), (k % 16) == 15);
      checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_in_ready_drop stall cycles %0d want 0", stalls); end
      wait_log(32, got);
      checks++; if (got != 32) begin errors++; $display("FAIL b2b_count got %0d words want 32", got); end
      if (got == 32) begin
         checks++; if (q_cyc[31] - q_cyc[0] != 31) begin errors++; $display("FAIL b2b_contiguous span %0d cycles want 31", q_cyc[31] - q_cyc[0]); end
      end
      for (int j = 0; j < q_data.size(); j++) begin
         e = 32'(16 * (j / 16)) + exp_ord[j % 16];
         checks++;
         if (q_data[j] !== e || q_idx[j] !== 4'(j % 16) || q_last[j] !== ((j % 16) == 15)) begin
            errors++;
            $display("FAIL b2b_word[%0d] data=%0d idx=%0d last=%b want %0d/%0d/%b", j, q_data[j], q_idx[j], q_last[j], e, j % 16, (j % 16) == 15);
         end
      end
   endtask

   task automatic test_backpressure();
      int got;
      int bad;
      int n;
      logic [31:0] e;
      clear_log();
      stalls = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 32; k++) send_one(32'(k), (k % 16) == 15);
      checks++; if (stalls != 0) begin errors++; $display("FAIL bp_early_stall stall cycles %0d want 0", stalls); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop got %b want 0", in_ready); end
      in_valid = 1'b1;
      in_data  = 32'd32;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== 4'd0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold %0d cycles with in_ready!=0 or output not holding index 0, want 0", bad); end
      out_ready = 1'b1;
      bad = 0;
      n = 0;
      while (!(out_valid === 1'b1 && out_index === 4'd15) && n < 100) begin
         if (in_ready !== 1'b0) bad++;
         tick();
         n++;
      end
      checks++; if (bad != 0 || n != 15) begin errors++; $display("FAIL bp_ready_early in_ready high %0d cycles, index15 after %0d cycles, want 0 and 15", bad, n); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return in_ready=%b when index 15 loaded, want 1", in_ready); end
      for (int k = 32; k < 48; k++) send_one(32'(k), (k % 16) == 15);
      wait_log(48, got);
      checks++; if (got != 48) begin errors++; $display("FAIL bp_count got %0d words want 48", got); end
      for (int j = 0; j < q_data.size(); j++) begin
         e = 32'(16 * (j / 16)) + exp_ord[j % 16];
         checks++;
         if (q_data[j] !== e || q_idx[j] !== 4'(j % 16) || q_last[j] !== ((j % 16) == 15)) begin
            errors++;
            $display("FAIL bp_word[%0d] data=%0d idx=%0d last=%b want %0d/%0d/%b", j, q_data[j], q_idx[j], q_last[j], e, j % 16, (j % 16) == 15);
         end
      end
   endtask

   task automatic test_random_stall();
      int got;
      bit done;
      logic [31:0] e;
      clear_log();
      stall_err = 0;
      stall_cyc = 0;
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 32; k++) send_one(32'(k), (k % 16) == 15);
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      out_ready = 1'b1;
      wait_log(32, got);
      tick();
      checks++; if (got != 32) begin errors++; $display("FAIL rnd_count got %0d words want 32", got); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL rnd_stable %0d stalled words changed, want 0", stall_err); end
      checks++; if (stall_cyc == 0) begin errors++; $display("FAIL rnd_stall_seen stall cycles %0d, want >0", stall_cyc); end
      for (int j = 0; j < q_data.size(); j++) begin
         e = 32'(16 * (j / 16)) + exp_ord[j % 16];
         checks++;
         if (q_data[j] !== e || q_idx[j] !== 4'(j % 16) || q_last[j] !== ((j % 16) == 15)) begin
            errors++;
            $display("FAIL rnd_word[%0d] data=%0d idx=%0d last=%b want %0d/%0d/%b", j, q_data[j], q_idx[j], q_last[j], e, j % 16, (j % 16) == 15);
         end
      end
   endtask

   task automatic test_frame_err();
      int got;
      clear_log();
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) send_one(32'(k), 1'b0);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_before got %b want 0", frame_err); end
      send_one(32'd7, 1'b1);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", frame_err); end
      for (int k = 8; k < 16; k++) send_one(32'(k), 1'b0);
      wait_log(16, got);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky got %b want 1", frame_err); end
      checks++; if (got != 16) begin errors++; $display("FAIL ferr_count got %0d words want 16", got); end
      for (int j = 0; j < q_data.size(); j++) begin
         checks++;
         if (q_data[j] !== exp_ord[j] || q_idx[j] !== 4'(j) || q_last[j] !== (j == 15)) begin
            errors++;
            $display("FAIL ferr_word[%0d] data=%0d idx=%0d last=%b want %0d/%0d/%b", j, q_data[j], q_idx[j], q_last[j], exp_ord[j], j, j == 15);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int got;
      out_ready = 1'b0;
      for (int k = 0; k < 16; k++) send_one(32'h50 + 32'(k), k == 15);
      for (int k = 0; k < 5; k++) send_one(32'(k), 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h50) begin errors++; $display("FAIL rst_pre valid=%b data=%0d want 1/80", out_valid, out_data); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 32'd0 || out_index !== 4'd0 || out_last !== 1'b0)
         begin errors++; $display("FAIL rst_async_outputs data=%0d idx=%0d last=%b want 0/0/0", out_data, out_index, out_last); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_async_ferr got %b want 0", frame_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready got %b want 1", in_ready); end
      #1;
      rst_n = 1'b1;
      tick();
      clear_log();
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) send_one(32'(k), k == 15);
      wait_log(16, got);
      repeat (5) tick();
      checks++; if (q_data.size() != 16) begin errors++; $display("FAIL rst_count got %0d words want 16", q_data.size()); end
      for (int j = 0; j < q_data.size(); j++) begin
         checks++;
         if (q_data[j] !== exp_ord[j] || q_idx[j] !== 4'(j) || q_last[j] !== (j == 15)) begin
            errors++;
            $display("FAIL rst_word[%0d] data=%0d idx=%0d last=%b want %0d/%0d/%b", j, q_data[j], q_idx[j], q_last[j], exp_ord[j], j, j == 15);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      stalls    = 0;
      stall_err = 0;
      stall_cyc = 0;
      held_vld  = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_random_stall();
      test_frame_err();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
